// File: rtl/q34_unpack_expand_pkg.sv
// Shared constants, state type and helpers for the Q3.4 unpack/expand block.
// Four signed Q3.4 lanes per packed word are widened to a signed Q format.
package q34_unpack_expand_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    typedef enum logic {
        EMPTY,
        BUSY
    } state_e;

    // Index of the final lane; out-of-range counts (0, 5..7) mean a full word.
    function automatic logic [1:0] last_lane(input logic [2:0] cnt);
        logic [1:0] r;
        if (cnt == 3'd0 || cnt > 3'd4) begin
            r = 2'd3;
        end else begin
            r = 2'(cnt - 3'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/q34_expand.sv
// Lossless widening of one signed Q3.4 lane into the output Q format.
// Integer part is sign-extended, low fraction bits are zero-filled.
module q34_expand
    import q34_unpack_expand_pkg::*;
#(
    parameter int DATA_WIDTH = 19,
    parameter int INT_LENGTH = 10
) (
    input  logic [LANE_W-1:0]     lane_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int SHIFT = DATA_WIDTH - INT_LENGTH - 5;

    if (INT_LENGTH < 3 || DATA_WIDTH - INT_LENGTH - 1 < 4) begin : g_bad_params
        $error("q34_expand: need INT_LENGTH>=3 and >=4 fraction bits");
    end

    logic signed [DATA_WIDTH-1:0] ext;

    assign ext    = DATA_WIDTH'($signed(lane_i));
    assign data_o = ext <<< SHIFT;

endmodule

// File: rtl/q34_unpack_expand.sv
// Unpacks up to four Q3.4 lanes per word and streams them out widened.
// Single holding register; back-to-back words run with no bubble.
module q34_unpack_expand
    import q34_unpack_expand_pkg::*;
#(
    parameter int DATA_WIDTH = 19,
    parameter int INT_LENGTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic [2:0]            in_count,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  lidx_q, lidx_d;
    logic [1:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic              is_busy;
    logic              at_end;
    logic              accept;
    logic              load;
    logic [LANE_W-1:0] lane;
    logic [DATA_WIDTH-1:0] exp_data;

    assign is_busy = (state_q == BUSY);
    assign at_end  = (idx_q == lidx_q);
    assign lane    = word_q[{idx_q, 3'b000} +: LANE_W];

    q34_expand #(
        .DATA_WIDTH (DATA_WIDTH),
        .INT_LENGTH (INT_LENGTH)
    ) u_expand (
        .lane_i (lane),
        .data_o (exp_data)
    );

    // Next-state, handshake and output decode from the holding register.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        lidx_d    = lidx_q;
        idx_d     = idx_q;
        last_d    = last_q;
        load      = 1'b0;
        in_ready  = !is_busy || (out_ready && at_end);
        accept    = in_valid && in_ready;
        out_valid = is_busy;
        out_data  = is_busy ? exp_data : '0;
        out_last  = is_busy && at_end && last_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (!at_end) begin
                        idx_d = idx_q + 2'd1;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            word_d = in_data;
            lidx_d = last_lane(in_count);
            idx_d  = 2'd0;
            last_d = in_last;
        end
    end

    // State and holding register; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            word_q  <= '0;
            lidx_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lidx_q  <= lidx_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_q34_unpack_expand.sv
// Scoreboard bench for q34_unpack_expand with default parameters.
// Expected lanes are queued on input accept and popped on output handshake.
module tb_q34_unpack_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_count = 3'd4;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [18:0] out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;
    int pops = 0;

    logic [19:0] sb[$];
    logic        held_v = 1'b0;
    logic [18:0] held_d = '0;
    logic        held_l = 1'b0;

    q34_unpack_expand dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] model(input logic [7:0] b);
        int v;
        v = $signed(b);
        v = v * 16;
        return v[18:0];
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        int n;
        logic [19:0] e;
        #4;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d
                    || out_last !== held_l) begin
                    errors++;
                    $display("FAIL stall_hold got %b %h %b want 1 %h %b",
                             out_valid, out_data, out_last, held_d, held_l);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (in_valid && in_ready) begin
                n = (in_count == 0 || in_count > 4) ? 4 : int'(in_count);
                for (int k = 0; k < n; k++) begin
                    sb.push_back({in_last && (k == n - 1),
                                  model(in_data[8*k +: 8])});
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h %b want none",
                             out_data, out_last);
                end else begin
                    e = sb.pop_front();
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL sb_elem got %b %h want %b %h",
                                 out_last, out_data, e[19], e[18:0]);
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [2:0] c,
                             input logic l);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        in_last  = l;
        for (int t = 0; t < 200 && !done; t++) begin
            #4;
            done = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 want accept");
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            if (sb.size() == 0 && !out_valid) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain got left=%0d want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_data !== 19'h0) begin
            errors++;
            $display("FAIL rst_data got %h want 0", out_data);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_last got %b want 0", out_last);
        end
    endtask

    task automatic test_basic();
        logic [18:0] ed[4];
        ed = '{19'h003C0, 19'h7F800, 19'h007F0, 19'h7FF10};
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hF17F803C;
        in_count = 3'd4;
        in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ed[i]
                || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_lane%0d got %b %h %b want 1 %h %b",
                         i, out_valid, out_data, out_last, ed[i], i == 3);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty got v=%b r=%b want 0 1",
                     out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_count2();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'hDEAD1080;
        in_count = 3'd2;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 19'h7F800
            || out_last !== 1'b0) begin
            errors++;
            $display("FAIL cnt2_l0 got %b %h %b want 1 7f800 0",
                     out_valid, out_data, out_last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 19'h00100
            || out_last !== 1'b1) begin
            errors++;
            $display("FAIL cnt2_l1 got %b %h %b want 1 00100 1",
                     out_valid, out_data, out_last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL cnt2_empty got v=%b r=%b want 0 1",
                     out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_count0();
        int nv;
        int lp;
        nv = 0;
        lp = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h8001_7FFE;
        in_count = 3'd0;
        in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #4;
            if (out_valid) begin
                nv++;
                if (out_last) lp = nv;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (nv != 4 || lp != 4) begin
            errors++;
            $display("FAIL cnt0 got n=%0d last@%0d want 4 4", nv, lp);
        end
        drain();
        send_word(32'h0403_0201, 3'd5, 1'b0);
        drain();
        send_word(32'hC0DE_AB12, 3'd7, 1'b1);
        drain();
        send_word(32'h7F80_0102, 3'd3, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] rp;
        int vc;
        logic drop;
        rp = '0;
        vc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h0102_0304;
        in_count = 3'd4;
        in_last = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_data = 32'hFDFE_FF80;
        in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #4;
            rp[i] = in_ready;
            if (out_valid) vc++;
            drop = in_ready;
            @(negedge clk);
            if (drop) in_valid = 1'b0;
        end
        checks++;
        if (vc != 8) begin
            errors++;
            $display("FAIL b2b_valid got %0d want 8", vc);
        end
        checks++;
        if (rp !== 8'b1000_1000) begin
            errors++;
            $display("FAIL b2b_ready got %b want 10001000", rp);
        end
        drain();
    endtask

    task automatic test_stall();
        int p0;
        p0 = pops;
        @(negedge clk);
        fork
            begin
                send_word(32'h9A5C_7F01, 3'd4, 1'b0);
                send_word(32'h8081_FE33, 3'd4, 1'b1);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        checks++;
        if (pops - p0 != 8) begin
            errors++;
            $display("FAIL stall_count got %0d want 8", pops - p0);
        end
    endtask

    task automatic test_reset_midword();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h1122_3344;
        in_count = 3'd4;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 19'h00330) begin
            errors++;
            $display("FAIL mid_lane1 got %b %h want 1 00330",
                     out_valid, out_data);
        end
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 19'h0
            || in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got %b %h %b %b want 0 0 1 0",
                     out_valid, out_data, in_ready, out_last);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #4;
            if (out_valid) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_residue got valid want none");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count2();
        test_count0();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
